// File: rtl/daq_rate_sel_ctrl.sv
// ============================================================================
// Module   : daq_rate_sel_ctrl
// Purpose  : Line-rate change sequencer (refclk -> word clock -> clock divider
//            reset -> PCS reset). Optional watchdog: DAQ_RATE_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module daq_rate_sel_ctrl #(
    parameter int NUM_RATES   = 4,
    parameter int RATE_W      = 2,
    parameter int RST_RATE    = 0,
    parameter int WRD_HOLD    = 4,
    parameter int PCS_HOLD    = 4,
    parameter int TIMEOUT_CYC = 1023
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [RATE_W-1:0]      RATE_REQ,
    input  logic [6*NUM_RATES-1:0] RATE_CFG,
    input  logic                   TXRATEDONE,
    input  logic                   CDV_DONE,
    output logic                   CDV_INIT,
    output logic [2:0]             CLK_SEL,
    output logic [1:0]             RATE_SEL,
    output logic                   WRDCLKSEL,
    output logic                   PCSRST,
    output logic [RATE_W-1:0]      CUR_RATE,
    output logic [NUM_RATES-1:0]   RATE_ONEHOT,
    output logic                   BUSY,
    output logic                   DONE_PLS,
    output logic                   BAD_REQ,
    output logic                   TIMEOUT_ERR,
    output logic [2:0]             DQRT_STATE
);

    typedef enum logic [2:0] {
        ST_STEADY    = 3'd0,
        ST_REFCLK    = 3'd1,
        ST_WRDCLK    = 3'd2,
        ST_RSTCLKDIV = 3'd3,
        ST_RSTPCS    = 3'd4
    } state_t;

    localparam int c_hold_max = (WRD_HOLD > PCS_HOLD) ? WRD_HOLD : PCS_HOLD;
    localparam int c_cnt_max  = (c_hold_max > TIMEOUT_CYC) ? c_hold_max : TIMEOUT_CYC;
    localparam int c_cnt_w    = $clog2(c_cnt_max + 1);

    localparam logic [c_cnt_w:0]       c_wrd_hold = (c_cnt_w+1)'(WRD_HOLD);
    localparam logic [c_cnt_w:0]       c_pcs_hold = (c_cnt_w+1)'(PCS_HOLD);
    localparam logic [c_cnt_w:0]       c_cnt_one  = (c_cnt_w+1)'(1);
    localparam logic [RATE_W:0]        c_num_rates = (RATE_W+1)'(NUM_RATES);
    localparam logic [RATE_W-1:0]      c_rst_rate = RATE_W'(RST_RATE);
    localparam logic [NUM_RATES-1:0]   c_one_hot0 = NUM_RATES'(1);
`ifdef DAQ_RATE_TIMEOUT_EN
    localparam logic [c_cnt_w:0]       c_timeout  = (c_cnt_w+1)'(TIMEOUT_CYC);
`endif

    state_t               r_state, w_nxt_state;
    logic [RATE_W-1:0]    r_cur, r_tgt, w_cur_nxt, w_tgt_nxt;
    logic [c_cnt_w-1:0]   r_cnt, w_cnt_nxt;
    logic [c_cnt_w:0]     w_cnt_inc;
    logic                 w_req_ok, r_req_bad;
    logic [RATE_W-1:0]    r_req_prev;
    logic                 w_done_nxt, w_bad_nxt, w_timeout;
    logic [5:0]           w_cfg [1<<RATE_W];
    logic [5:0]           w_sel_cfg, w_cur_cfg;

    logic                 r_cdv_init, r_wrdclksel, r_pcsrst, r_busy;
    logic                 r_done, r_bad, r_terr;
    logic [2:0]           r_clk_sel;
    logic [1:0]           r_rate_sel;
    logic [NUM_RATES-1:0] r_onehot;

    // Unused index slots read as zero so any RATE_W-wide index is safe.
    for (genvar gi = 0; gi < (1 << RATE_W); gi++) begin : g_cfg
        if (gi < NUM_RATES) begin : g_used
            assign w_cfg[gi] = RATE_CFG[6*gi +: 6];
        end else begin : g_pad
            assign w_cfg[gi] = 6'd0;
        end
    end

    assign w_req_ok  = ({1'b0, RATE_REQ} < c_num_rates);
    assign w_cnt_inc = {1'b0, r_cnt} + c_cnt_one;

    always_comb begin
        w_nxt_state = r_state;
        w_tgt_nxt   = r_tgt;
        w_cur_nxt   = r_cur;
        w_cnt_nxt   = '0;
        w_done_nxt  = 1'b0;
        w_bad_nxt   = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            ST_STEADY: begin
                if (w_req_ok && (RATE_REQ != r_cur)) begin
                    w_nxt_state = ST_REFCLK;
                    w_tgt_nxt   = RATE_REQ;
                end else if (!w_req_ok && !(r_req_bad && (RATE_REQ == r_req_prev))) begin
                    w_bad_nxt = 1'b1;
                end
            end
            ST_REFCLK: begin
                if (TXRATEDONE) begin
                    w_nxt_state = ST_WRDCLK;
                end else begin
`ifdef DAQ_RATE_TIMEOUT_EN
                    if (w_cnt_inc == c_timeout) begin
                        w_timeout = 1'b1;
                    end else begin
                        w_cnt_nxt = w_cnt_inc[c_cnt_w-1:0];
                    end
`endif
                end
            end
            ST_WRDCLK: begin
                if (w_cnt_inc == c_wrd_hold) begin
                    w_nxt_state = ST_RSTCLKDIV;
                end else begin
                    w_cnt_nxt = w_cnt_inc[c_cnt_w-1:0];
                end
            end
            ST_RSTCLKDIV: begin
                if (CDV_DONE) begin
                    w_nxt_state = ST_RSTPCS;
                end else begin
`ifdef DAQ_RATE_TIMEOUT_EN
                    if (w_cnt_inc == c_timeout) begin
                        w_timeout   = 1'b1;
                        w_nxt_state = ST_REFCLK;
                    end else begin
                        w_cnt_nxt = w_cnt_inc[c_cnt_w-1:0];
                    end
`endif
                end
            end
            ST_RSTPCS: begin
                if (w_cnt_inc == c_pcs_hold) begin
                    w_nxt_state = ST_STEADY;
                    w_cur_nxt   = r_tgt;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt = w_cnt_inc[c_cnt_w-1:0];
                end
            end
            default: w_nxt_state = ST_STEADY;
        endcase
    end

    // Selects follow the target during a transition, except that the word
    // clock keeps the old rate until the reference clock has switched.
    assign w_cur_cfg = w_cfg[w_cur_nxt];
    assign w_sel_cfg = (w_nxt_state == ST_STEADY) ? w_cur_cfg : w_cfg[w_tgt_nxt];

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= ST_STEADY;
            r_cur       <= c_rst_rate;
            r_tgt       <= c_rst_rate;
            r_cnt       <= '0;
            r_req_bad   <= 1'b0;
            r_req_prev  <= '0;
            r_cdv_init  <= 1'b1;
            r_pcsrst    <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_bad       <= 1'b0;
            r_terr      <= 1'b0;
            r_clk_sel   <= w_cfg[c_rst_rate][2:0];
            r_rate_sel  <= w_cfg[c_rst_rate][4:3];
            r_wrdclksel <= w_cfg[c_rst_rate][5];
            r_onehot    <= c_one_hot0 << c_rst_rate;
        end else begin
            r_state     <= w_nxt_state;
            r_cur       <= w_cur_nxt;
            r_tgt       <= w_tgt_nxt;
            r_cnt       <= w_cnt_nxt;
            r_req_bad   <= !w_req_ok;
            r_req_prev  <= RATE_REQ;
            r_cdv_init  <= (w_nxt_state == ST_REFCLK) || (w_nxt_state == ST_WRDCLK);
            r_pcsrst    <= (w_nxt_state == ST_RSTPCS);
            r_busy      <= (w_nxt_state != ST_STEADY);
            r_done      <= w_done_nxt;
            r_bad       <= w_bad_nxt;
            r_terr      <= r_terr | w_timeout;
            r_clk_sel   <= w_sel_cfg[2:0];
            r_rate_sel  <= w_sel_cfg[4:3];
            r_wrdclksel <= (w_nxt_state == ST_REFCLK) ? w_cur_cfg[5] : w_sel_cfg[5];
            r_onehot    <= (w_nxt_state != ST_STEADY) ? '0 : (c_one_hot0 << w_cur_nxt);
        end
    end

    assign CDV_INIT    = r_cdv_init;
    assign CLK_SEL     = r_clk_sel;
    assign RATE_SEL    = r_rate_sel;
    assign WRDCLKSEL   = r_wrdclksel;
    assign PCSRST      = r_pcsrst;
    assign CUR_RATE    = r_cur;
    assign RATE_ONEHOT = r_onehot;
    assign BUSY        = r_busy;
    assign DONE_PLS    = r_done;
    assign BAD_REQ     = r_bad;
    assign TIMEOUT_ERR = r_terr;
    assign DQRT_STATE  = r_state;

endmodule

`default_nettype wire

// File: tb/tb_daq_rate_sel_ctrl.sv
// ============================================================================
// Module   : tb_daq_rate_sel_ctrl
// Purpose  : Directed self-checking bench for daq_rate_sel_ctrl with a
//            completion scoreboard of requested rates.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_daq_rate_sel_ctrl;

    localparam int NUM_RATES   = 4;
    localparam int RATE_W      = 3;
    localparam int RST_RATE    = 0;
    localparam int WRD_HOLD    = 4;
    localparam int PCS_HOLD    = 4;
    localparam int TIMEOUT_CYC = 1023;

    localparam logic [5:0] CFG_TAB [4] = '{6'h01, 6'h2A, 6'h14, 6'h3B};

    logic                   CLK = 1'b0;
    logic                   RST;
    logic [RATE_W-1:0]      RATE_REQ;
    logic [6*NUM_RATES-1:0] RATE_CFG;
    logic                   TXRATEDONE, CDV_DONE;
    logic                   CDV_INIT, WRDCLKSEL, PCSRST, BUSY, DONE_PLS, BAD_REQ, TIMEOUT_ERR;
    logic [2:0]             CLK_SEL, DQRT_STATE;
    logic [1:0]             RATE_SEL;
    logic [RATE_W-1:0]      CUR_RATE;
    logic [NUM_RATES-1:0]   RATE_ONEHOT;

    int n_tests = 0;
    int n_fail  = 0;
    int m_cur   = RST_RATE;
    bit m_terr  = 1'b0;
    int sb[$];

    assign RATE_CFG = {CFG_TAB[3], CFG_TAB[2], CFG_TAB[1], CFG_TAB[0]};

    always #5 CLK = ~CLK;

    daq_rate_sel_ctrl #(
        .NUM_RATES(NUM_RATES), .RATE_W(RATE_W), .RST_RATE(RST_RATE),
        .WRD_HOLD(WRD_HOLD), .PCS_HOLD(PCS_HOLD), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .CLK(CLK), .RST(RST), .RATE_REQ(RATE_REQ), .RATE_CFG(RATE_CFG),
        .TXRATEDONE(TXRATEDONE), .CDV_DONE(CDV_DONE), .CDV_INIT(CDV_INIT),
        .CLK_SEL(CLK_SEL), .RATE_SEL(RATE_SEL), .WRDCLKSEL(WRDCLKSEL),
        .PCSRST(PCSRST), .CUR_RATE(CUR_RATE), .RATE_ONEHOT(RATE_ONEHOT),
        .BUSY(BUSY), .DONE_PLS(DONE_PLS), .BAD_REQ(BAD_REQ),
        .TIMEOUT_ERR(TIMEOUT_ERR), .DQRT_STATE(DQRT_STATE)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [5:0] cfg(input int r);
        return CFG_TAB[r];
    endfunction

    // {state,busy,cdv,pcs,wrd,rate_sel,clk_sel,cur,onehot,done,bad,terr}
    function automatic logic [21:0] exp_vec(input int st, input int tgt, input bit done,
                                            input bit bad, input bit rst);
        logic [5:0] cc, ct, s;
        logic       wrd;
        logic [3:0] oh;
        cc  = cfg(m_cur);
        ct  = cfg(tgt);
        s   = (st == 0) ? cc : ct;
        wrd = (st == 1) ? cc[5] : s[5];
        oh  = (st == 0) ? (4'b0001 << m_cur) : 4'b0000;
        return {3'(st), st != 0, rst || st == 1 || st == 2, st == 4, wrd, s[4:3], s[2:0],
                3'(m_cur), oh, done, bad, m_terr};
    endfunction

    function automatic logic [21:0] obs_vec();
        return {DQRT_STATE, BUSY, CDV_INIT, PCSRST, WRDCLKSEL, RATE_SEL, CLK_SEL,
                CUR_RATE, RATE_ONEHOT, DONE_PLS, BAD_REQ, TIMEOUT_ERR};
    endfunction

    task automatic chk_st(input string tag, input int st, input int tgt, input bit done,
                          input bit bad, input bit rst);
        chk(tag, 32'(obs_vec()), 32'(exp_vec(st, tgt, done, bad, rst)));
    endtask

    // Entered in a STEADY window with RATE_REQ = tgt already driven.
    task automatic xfer(input int tgt, input int mid, input int txdly, input int cdvdly,
                        input int abort_at);
        int exp_rate;
        tick();
        for (int i = 0; i <= txdly; i++) begin
`ifdef DAQ_RATE_TIMEOUT_EN
            if (i == TIMEOUT_CYC) m_terr = 1'b1;
`endif
            chk_st($sformatf("refclk[%0d]", i), 1, tgt, 0, 0, 0);
            if (i == txdly) TXRATEDONE = 1'b1;
            tick();
        end
        TXRATEDONE = 1'b0;
        for (int i = 0; i < WRD_HOLD; i++) begin
            chk_st($sformatf("wrdclk[%0d]", i), 2, tgt, 0, 0, 0);
            if (i == 0) begin
                TXRATEDONE = 1'b1;
                CDV_DONE   = 1'b1;
                if (mid >= 0) begin
                    RATE_REQ = RATE_W'(mid);
                    sb.push_back(mid);
                end
            end
            if (i == WRD_HOLD - 1) begin
                TXRATEDONE = 1'b0;
                CDV_DONE   = 1'b0;
            end
            tick();
        end
        for (int i = 0; i <= cdvdly; i++) begin
            chk_st($sformatf("rstclkdiv[%0d]", i), 3, tgt, 0, 0, 0);
            if (i == cdvdly) CDV_DONE = 1'b1;
            tick();
        end
        CDV_DONE = 1'b0;
        for (int i = 0; i < PCS_HOLD; i++) begin
            chk_st($sformatf("rstpcs[%0d]", i), 4, tgt, 0, 0, 0);
            if (i == abort_at) begin
                RST      = 1'b1;
                RATE_REQ = RATE_W'(RST_RATE);
                tick();
                RST    = 1'b0;
                m_cur  = RST_RATE;
                m_terr = 1'b0;
                if (sb.size() != 0) void'(sb.pop_front());
                chk_st("abort_rst", 0, m_cur, 0, 0, 1);
                tick();
                chk_st("abort_steady", 0, m_cur, 0, 0, 0);
                return;
            end
            tick();
        end
        m_cur = tgt;
        chk_st("done", 0, tgt, 1, 0, 0);
        exp_rate = (sb.size() != 0) ? sb.pop_front() : -1;
        chk("sb_cur_rate", 32'(CUR_RATE), 32'(exp_rate));
        chk("sb_onehot", 32'(RATE_ONEHOT), 32'(4'b0001 << exp_rate));
    endtask

    initial begin
        RST        = 1'b1;
        RATE_REQ   = RATE_W'(RST_RATE);
        TXRATEDONE = 1'b0;
        CDV_DONE   = 1'b0;
        repeat (3) tick();
        chk_st("reset", 0, m_cur, 0, 0, 1);
        RST = 1'b0;
        tick();
        chk_st("steady_after_reset", 0, m_cur, 0, 0, 0);

        // Basic transition 0 -> 2.
        RATE_REQ = 3'd2;
        sb.push_back(2);
        xfer(2, -1, 3, 2, -1);
        tick();
        chk_st("done_one_cycle", 0, m_cur, 0, 0, 0);

        // Out-of-range requests, including the first invalid index.
        RATE_REQ = 3'd5;
        tick();
        chk_st("bad5_pulse", 0, m_cur, 0, 1, 0);
        tick();
        chk_st("bad5_held", 0, m_cur, 0, 0, 0);
        RATE_REQ = 3'd4;
        tick();
        chk_st("bad4_pulse", 0, m_cur, 0, 1, 0);
        RATE_REQ = 3'd2;
        tick();
        chk_st("same_rate", 0, m_cur, 0, 0, 0);
        tick();
        chk_st("same_rate_idle", 0, m_cur, 0, 0, 0);

        // Request changes mid-transition; the new one follows back-to-back.
        RATE_REQ = 3'd1;
        sb.push_back(1);
        xfer(1, 3, 0, 0, -1);
        xfer(3, -1, 1, 1, -1);

        // Reset pulse during the PCS reset phase.
        RATE_REQ = 3'd1;
        sb.push_back(1);
        xfer(1, -1, 0, 0, 2);

`ifdef DAQ_RATE_TIMEOUT_EN
        RATE_REQ = 3'd2;
        sb.push_back(2);
        xfer(2, -1, TIMEOUT_CYC + 7, 0, -1);
`endif

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/daq_rate_sel_ctrl.md
DAQ_RATE_SEL_CTRL -- requirements
Module: daq_rate_sel_ctrl

Interface
REQ-001 The block SHALL have parameter NUM_RATES, default 4: number of selectable line rates (2..8).
REQ-002 The block SHALL have parameter RATE_W, default 2: width of the rate index, where 2**RATE_W >= NUM_RATES.
REQ-003 The block SHALL have parameter RST_RATE, default 0: rate index entered on reset.
REQ-004 The block SHALL have parameter WRD_HOLD, default 4: WRDCLK dwell in cycles (1..255).
REQ-005 The block SHALL have parameter PCS_HOLD, default 4: PCSRST assertion length in cycles (1..255).
REQ-006 The block SHALL have parameter TIMEOUT_CYC, default 1023: handshake watchdog limit in cycles.
REQ-007 Ports SHALL be as follows; one clock, and reset is synchronous and active-high.
- CLK  in  1  clock
- RST  in  1  synchronous active-high reset
- RATE_REQ  in  RATE_W  requested rate index
- RATE_CFG  in  6*NUM_RATES  per-rate {WRDCLKSEL, RATE_SEL[1:0], CLK_SEL[2:0]}, with rate i in bits [6i+5:6i]
- TXRATEDONE  in  1  transceiver rate change complete
- CDV_DONE  in  1  clock divider reset complete
- CDV_INIT  out  1  clock divider reset request
- CLK_SEL  out  3  reference clock select
- RATE_SEL  out  2  transceiver rate select
- WRDCLKSEL  out  1  word clock select
- PCSRST  out  1  PCS reset
- CUR_RATE  out  RATE_W  rate currently in service
- RATE_ONEHOT  out  NUM_RATES  one-hot decode of CUR_RATE; all zero while BUSY
- BUSY  out  1  transition in progress
- DONE_PLS  out  1  one-cycle pulse when a transition completes
- BAD_REQ  out  1  one-cycle pulse when an invalid request is rejected
- TIMEOUT_ERR  out  1  sticky watchdog error
- DQRT_STATE  out  3  encoded state, for debug

Function
REQ-008 The block SHALL implement the states STEADY=0, REFCLK=1, WRDCLK=2, RSTCLKDIV=3, RSTPCS=4.
REQ-009 All outputs SHALL be registered and decoded from nextstate, so that each output is valid in the same cycle as the state it belongs to.
REQ-010 In STEADY, a valid request (RATE_REQ < NUM_RATES and RATE_REQ != CUR_RATE) SHALL latch TGT=RATE_REQ and go to REFCLK on the next clock edge.
REQ-011 In STEADY, a request with RATE_REQ >= NUM_RATES SHALL pulse BAD_REQ for one cycle only on the cycle the value first appears, and the state SHALL be unchanged.
REQ-012 In REFCLK, the block SHALL drive CDV_INIT=1 and CLK_SEL/RATE_SEL from TGT, keep WRDCLKSEL from CUR_RATE, clear the counter, and go to WRDCLK when TXRATEDONE=1.
REQ-013 In WRDCLK, the block SHALL drive CDV_INIT=1 and WRDCLKSEL from TGT, increment the counter, and exit to RSTCLKDIV once the counter reaches WRD_HOLD.
REQ-014 In RSTCLKDIV, the block SHALL clear the counter and go to RSTPCS when CDV_DONE=1.
REQ-015 In RSTPCS, the block SHALL drive PCSRST=1 for exactly PCS_HOLD cycles, then go to STEADY with CUR_RATE=TGT and DONE_PLS=1 for one cycle.
REQ-016 Outside REFCLK, CLK_SEL/RATE_SEL/WRDCLKSEL SHALL reflect TGT during a transition and CUR_RATE in STEADY.
REQ-017 BUSY SHALL be 1 in every state other than STEADY.
REQ-018 Changes on RATE_REQ during BUSY SHALL be ignored; RATE_REQ SHALL be re-evaluated in the first STEADY cycle, so back-to-back transitions are legal.
REQ-019 TXRATEDONE/CDV_DONE asserted outside their waiting state SHALL be ignored.
REQ-020 The counter SHALL be clog2(max(WRD_HOLD, PCS_HOLD, TIMEOUT_CYC)+1) bits wide and SHALL never wrap.

Reset
REQ-021 While RST=1, the block SHALL hold state=STEADY, CUR_RATE=TGT=RST_RATE, and CLK_SEL/RATE_SEL/WRDCLKSEL from the RST_RATE entry.
REQ-022 While RST=1, the block SHALL hold CDV_INIT=1, PCSRST=0, BUSY=0, DONE_PLS=0, BAD_REQ=0, TIMEOUT_ERR=0, and counter=0.
REQ-023 RST asserted mid-transition SHALL abort the transition within one cycle, with no DONE_PLS.

Configuration
REQ-024 With DAQ_RATE_TIMEOUT_EN defined, the block SHALL count cycles while in REFCLK or RSTCLKDIV; at TIMEOUT_CYC it SHALL set TIMEOUT_ERR (sticky until RST) and restart at REFCLK with the same TGT.
REQ-025 Without DAQ_RATE_TIMEOUT_EN, the waits SHALL be unbounded and TIMEOUT_ERR SHALL be tied to 0.

Verification
REQ-026 Reset with RST_RATE=0, then RATE_REQ=2, TXRATEDONE after 3 cycles, CDV_DONE after 2 cycles -> REFCLK, WRDCLK (4 cycles), RSTCLKDIV, RSTPCS (4 cycles); CUR_RATE=2, DONE_PLS once, RATE_ONEHOT=4'b0100.
REQ-027 RATE_REQ=5 with NUM_RATES=4 -> BAD_REQ pulses for 1 cycle, BUSY stays 0, and outputs are unchanged.
REQ-028 RATE_REQ changes 1->3 while in WRDCLK -> the transition to 1 completes, then a second transition to 3 starts in the following STEADY cycle.
REQ-029 With DAQ_RATE_TIMEOUT_EN and TXRATEDONE held low for 1023 cycles -> TIMEOUT_ERR=1 and REFCLK is re-entered; TXRATEDONE then completes the transition with TIMEOUT_ERR still 1.
REQ-030 RST pulsed for 1 cycle during RSTPCS -> PCSRST drops the next cycle, CUR_RATE=RST_RATE, and no DONE_PLS is produced.
